// File: rtl/tgate_cfg_pkg.sv
// Shared types and constants for the serially configured transmission-gate switch array.
// A channel's config pair is {sel, selb} at bit offsets SEL_OFS/SELB_OFS within its 2-bit field.
package tgate_cfg_pkg;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StBreak = 2'd1,
    StMake  = 2'd2
  } state_e;

  localparam int unsigned SEL_OFS  = 1;
  localparam int unsigned SELB_OFS = 0;

  // Only the complementary pair 10 conducts; 00 and 11 are illegal and leave the channel off.
  function automatic logic pair_on(input logic sel, input logic selb);
    return sel & ~selb;
  endfunction

  function automatic logic pair_illegal(input logic sel, input logic selb);
    return sel == selb;
  endfunction

endpackage

// File: rtl/tgate_channel.sv
// One unidirectional transmission-gate channel: passes in to out when enabled,
// otherwise releases out to high impedance.
module tgate_channel #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output wire  [WIDTH-1:0] out
);

  assign out = en ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/tgate_switch_array_cfg.sv
// Programmable switch block: serial config frames are shifted into a shadow chain and
// committed with break-before-make (all channels Z for BBM_CYCLES, then one MAKE cycle).
module tgate_switch_array_cfg
  import tgate_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned BBM_CYCLES = 1
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_bit,
  input  logic                    cfg_abort,
  output logic                    busy,
  output logic                    cfg_err,
  output logic [NUM_CH-1:0]       ch_on,
  input  logic [NUM_CH*WIDTH-1:0] in,
  output wire  [NUM_CH*WIDTH-1:0] out
);

  localparam int unsigned FRAME_LEN = 2 * NUM_CH;
  localparam int unsigned CntW      = $clog2(FRAME_LEN + 1);
  localparam int unsigned BbmW      = $clog2(BBM_CYCLES + 1);

  localparam logic [CntW-1:0]      CntLast   = CntW'(FRAME_LEN - 1);
  localparam logic [BbmW-1:0]      BbmLast   = BbmW'(BBM_CYCLES - 1);
  // Every channel sel=0, selb=1 (legal OFF).
  localparam logic [FRAME_LEN-1:0] ActiveOff = {NUM_CH{2'b01}};

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [BbmW-1:0]      bbm_q, bbm_d;
  logic [FRAME_LEN-1:0] shadow_q, shadow_d;
  logic [FRAME_LEN-1:0] active_q, active_d;
  logic                 err_q, err_d;
  logic                 frame_illegal;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q  <= StLoad;
      count_q  <= '0;
      bbm_q    <= '0;
      shadow_q <= '0;
      active_q <= ActiveOff;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      bbm_q    <= bbm_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    frame_illegal = 1'b0;
    ch_on         = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      frame_illegal = frame_illegal |
                      pair_illegal(shadow_q[2*c+SEL_OFS], shadow_q[2*c+SELB_OFS]);
      // Outputs only conduct while idle in LOAD; BREAK and MAKE force every channel off.
      ch_on[c] = (state_q == StLoad) &&
                 pair_on(active_q[2*c+SEL_OFS], active_q[2*c+SELB_OFS]);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bbm_d     = bbm_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    err_d     = err_q;
    cfg_ready = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      StLoad: begin
        cfg_ready = 1'b1;
        // Abort takes priority over a bit offered in the same cycle.
        if (cfg_abort) begin
          count_d  = '0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          // Shift left so the first accepted bit ends up in the MSB.
          shadow_d = {shadow_q[FRAME_LEN-2:0], cfg_bit};
          if (count_q == CntLast) begin
            count_d = '0;
            bbm_d   = '0;
            state_d = StBreak;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      StBreak: begin
        busy = 1'b1;
        if (bbm_q == BbmLast) begin
          state_d = StMake;
        end else begin
          bbm_d = bbm_q + BbmW'(1);
        end
      end
      StMake: begin
        busy     = 1'b1;
        active_d = shadow_q;
        err_d    = err_q | frame_illegal;
        state_d  = StLoad;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  assign cfg_err = err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tgate_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .en (ch_on[c]),
      .in (in[c*WIDTH +: WIDTH]),
      .out(out[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_tgate_switch_array_cfg.sv
// Bench for tgate_switch_array_cfg (NUM_CH=4, WIDTH=2, BBM_CYCLES=1): directed frames, expected
// commit results queued at issue time and checked by a monitor when busy drops.
module tb_tgate_switch_array_cfg;

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_bit;
  logic       cfg_abort;
  logic       busy;
  logic       cfg_err;
  logic [3:0] ch_on;
  logic [7:0] in;
  wire  [7:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  ch_on;
    logic        err;
    int unsigned blen;
  } exp_t;

  exp_t sbq[$];

  tgate_switch_array_cfg #(
    .NUM_CH    (4),
    .WIDTH     (2),
    .BBM_CYCLES(1)
  ) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_bit  (cfg_bit),
    .cfg_abort(cfg_abort),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .ch_on    (ch_on),
    .in       (in),
    .out      (out)
  );

  always #5 prog_clk = ~prog_clk;

  function automatic logic [7:0] chmask(input logic [3:0] c);
    logic [7:0] m;
    for (int i = 0; i < 4; i++) m[2*i +: 2] = {2{c[i]}};
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic e, input int unsigned bl);
    exp_t x;
    x.ch_on = c;
    x.err   = e;
    x.blen  = bl;
    sbq.push_back(x);
  endtask

  // Offer nbits of frame MSB-first; optionally raise abort with the last bit, or keep valid high.
  task automatic send(input logic [7:0] frame, input int nbits, input logic abort_last,
                      input logic hold);
    for (int i = 0; i < nbits; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = frame[7-i];
      cfg_abort = abort_last && (i == nbits - 1);
      tick();
    end
    cfg_abort = 1'b0;
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: commit not seen, %0d pending, required 0", name, sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  // Monitor: count busy cycles, require outputs off and ready low while busy, compare on busy fall.
  initial begin
    logic        busy_prev;
    int unsigned blen;
    logic        viol;
    exp_t        e;
    busy_prev = 1'b0;
    blen      = 0;
    viol      = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (busy === 1'b1) begin
        blen++;
        if (ch_on !== 4'b0000 || cfg_ready !== 1'b0) viol = 1'b1;
      end else if (busy_prev) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got busy fall, required none at %0t", $time);
        end else begin
          e = sbq.pop_front();
          check("commit_ch_on", 32'(ch_on), 32'(e.ch_on));
          check("commit_cfg_err", 32'(cfg_err), 32'(e.err));
          check("commit_busy_len", blen, e.blen);
          check("commit_out", 32'(out & chmask(e.ch_on)), 32'(in & chmask(e.ch_on)));
          check("busy_outputs_off_ready_low", 32'(viol), 32'd0);
        end
        blen = 0;
        viol = 1'b0;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  initial begin
    pReset    = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    cfg_abort = 1'b0;
    in        = 8'hA5;
    tick();
    tick();
    check("reset_ch_on", 32'(ch_on), 32'h0);
    check("reset_cfg_ready", 32'(cfg_ready), 32'h1);
    check("reset_cfg_err", 32'(cfg_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    pReset = 1'b0;
    repeat (3) tick();
    check("idle_ch_on", 32'(ch_on), 32'h0);

    // ch3 on, ch1 on -> out = 10zz01zz
    push(4'b1010, 1'b0, 2);
    send(8'b10_01_10_01, 8, 1'b0, 1'b0);
    wait_drain("frame_1010");
    check("frame_1010_out_hi", 32'(out[7:6]), 32'h2);
    check("frame_1010_out_lo", 32'(out[3:2]), 32'h1);

    // ch3=11, ch1=00 illegal
    push(4'b0101, 1'b1, 2);
    send(8'b11_10_00_10, 8, 1'b0, 1'b0);
    wait_drain("frame_illegal");

    // Legal frame keeps the sticky error
    push(4'b1010, 1'b1, 2);
    send(8'b10_01_10_01, 8, 1'b0, 1'b0);
    wait_drain("frame_sticky");

    // 5 bits then abort with the 6th: config unchanged, next frame aligned
    send(8'b01_10_01_10, 6, 1'b1, 1'b0);
    repeat (3) tick();
    check("abort_ch_on_kept", 32'(ch_on), 32'hA);
    check("abort_no_busy", 32'(busy), 32'h0);
    push(4'b0101, 1'b1, 2);
    send(8'b01_10_01_10, 8, 1'b0, 1'b0);
    wait_drain("frame_after_abort");

    // Valid held through BREAK/MAKE: no bits consumed
    push(4'b1111, 1'b1, 2);
    send(8'b10_10_10_10, 8, 1'b0, 1'b1);
    cfg_bit = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b0;
    wait_drain("frame_hold_valid");
    push(4'b0000, 1'b1, 2);
    send(8'b01_01_01_01, 8, 1'b0, 1'b0);
    wait_drain("frame_after_hold");

    // Reset during BREAK: commit lost, error cleared
    push(4'b0000, 1'b0, 1);
    send(8'b10_10_10_10, 8, 1'b0, 1'b0);
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    wait_drain("reset_in_break");
    repeat (2) tick();
    check("reset_break_ch_on", 32'(ch_on), 32'h0);
    check("reset_break_cfg_err", 32'(cfg_err), 32'h0);
    check("reset_break_ready", 32'(cfg_ready), 32'h1);
    push(4'b1010, 1'b0, 2);
    send(8'b10_01_10_01, 8, 1'b0, 1'b0);
    wait_drain("frame_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
